// File: rtl/mul_add_sub_pkg.sv
// Shared definitions for the sequential Booth multiply / add / subtract unit:
// operation encodings and the controller state type.
package mul_add_sub_pkg;

  // Operation select applied in the final (FIX) cycle
  localparam logic [1:0] OP_ADD = 2'b00;  // product + sext(in3)
  localparam logic [1:0] OP_SUB = 2'b01;  // product - sext(in3)
  localparam logic [1:0] OP_ACC = 2'b10;  // aluOut  + product
  localparam logic [1:0] OP_MUL = 2'b11;  // product only

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_add_sub_seq_booth_step.sv
// One radix-2 Booth iteration: inspect {Q[0], Q[-1]}, add/subtract/hold the
// multiplicand into the N+1-bit partial product A, then shift {A, Q, Q[-1]}
// right arithmetically by one. Purely combinational.
module booth_step #(
  parameter int N = 4
) (
  input  logic [N:0]   i_a,    // partial product (upper half), N+1 bits
  input  logic [N-1:0] i_q,    // multiplier / lower product bits
  input  logic         i_qm1,  // Q[-1]
  input  logic [N:0]   i_m,    // multiplicand, sign-extended to N+1 bits
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q,
  output logic         o_qm1
);

  logic [N:0] w_sum;

  // Select add, subtract or hold of the multiplicand from the Booth pair
  always_comb begin
    // NOTE: default assignment first so every path drives w_sum and no latch is inferred.
    w_sum = i_a;
    case ({i_q[0], i_qm1})
      2'b10:   w_sum = i_a - i_m;
      2'b01:   w_sum = i_a + i_m;
      default: w_sum = i_a;
    endcase
  end

  // Arithmetic shift right of the combined {A, Q, Q[-1]} register
  assign o_a   = {w_sum[N], w_sum[N:1]};
  assign o_q   = {w_sum[0], i_q[N-1:1]};
  assign o_qm1 = i_q[0];

endmodule

// File: rtl/mul_add_sub_seq.sv
// Sequential signed multiplier with a post-multiply add / subtract /
// accumulate stage. A load captures all operands, N Booth steps run one per
// cycle, a single FIX cycle forms the W-bit result and overflow flag, and a
// DONE cycle presents a one-cycle done pulse (a load there restarts at once).
module mul_add_sub_seq
  import mul_add_sub_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2 * N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [1:0]   op,
  input  logic [N-1:0] multiplier,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] in3,
  output logic [W-1:0] aluOut,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam int             CW       = $clog2(N + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(N);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t          r_state;
  logic [N:0]      r_a;
  logic [N-1:0]    r_q;
  logic            r_qm1;
  logic [N:0]      r_m;
  logic [N-1:0]    r_in3;
  logic [1:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_alu_out;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  logic [N:0]      w_a_nxt;
  logic [N-1:0]    w_q_nxt;
  logic            w_qm1_nxt;
  logic [W-1:0]    w_product;
  logic [W-1:0]    w_in3_ext;
  logic [W-1:0]    w_result;
  logic            w_ovf;

  booth_step #(.N(N)) u_booth_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_qm1 (r_qm1),
    .i_m   (r_m),
    .o_a   (w_a_nxt),
    .o_q   (w_q_nxt),
    .o_qm1 (w_qm1_nxt)
  );

  // After N steps the low N bits of A over Q hold the exact 2N-bit product
  assign w_product = {r_a[N-1:0], r_q};
  assign w_in3_ext = {{(W - N){r_in3[N-1]}}, r_in3};

  // Final W-bit add/sub/accumulate with signed-overflow detection
  always_comb begin
    w_result = w_product;
    w_ovf    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result = w_product + w_in3_ext;
        w_ovf    = (w_product[W-1] == w_in3_ext[W-1]) && (w_result[W-1] != w_product[W-1]);
      end
      OP_SUB: begin
        w_result = w_product - w_in3_ext;
        w_ovf    = (w_product[W-1] != w_in3_ext[W-1]) && (w_result[W-1] != w_product[W-1]);
      end
      OP_ACC: begin
        w_result = r_alu_out + w_product;
        w_ovf    = (r_alu_out[W-1] == w_product[W-1]) && (w_result[W-1] != r_alu_out[W-1]);
      end
      default: begin
        w_result = w_product;
        w_ovf    = 1'b0;
      end
    endcase
  end

  // Controller FSM with registered outputs; reset clears every register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_in3     <= '0;
      r_op      <= OP_ADD;
      r_cnt     <= '0;
      r_alu_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (load) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_qm1   <= 1'b0;
            r_m     <= {multiplicand[N-1], multiplicand};
            r_in3   <= in3;
            r_op    <= op;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_alu_out <= w_result;
          r_ovf     <= w_ovf;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign aluOut = r_alu_out;
  assign busy   = r_busy;
  assign done   = r_done;
  assign ovf    = r_ovf;

endmodule
